// File: rtl/mesi_line_controller.sv
// rtl/mesi_line_controller.sv - MESI line-state sequencer with front-side-bus transaction control
// Looks up one line per command, runs at most one bus op, writes the next state back and responds.
module mesi_line_controller #(
  parameter int IDX_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [7:0]       REQ_CMD,
  input  logic [IDX_W-1:0] REQ_INDEX,
  output logic             BUS_REQ,
  output logic [1:0]       BUS_OP,
  input  logic             BUS_GNT,
  input  logic             BUS_DONE,
  input  logic [1:0]       BUS_HM,
  output logic             RSP_VALID,
  output logic [3:0]       RSP_STATE,
  output logic             RSP_HIT,
  output logic [1:0]       SNOOP_RESULT,
  output logic             BUSY
);

  localparam logic [3:0] ST_M = 4'b0001;
  localparam logic [3:0] ST_E = 4'b0010;
  localparam logic [3:0] ST_S = 4'b0100;
  localparam logic [3:0] ST_I = 4'b1000;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RWIM = 2'd1;
  localparam logic [1:0] OP_INV  = 2'd2;
  localparam logic [1:0] OP_WB   = 2'd3;

  localparam logic [1:0] SR_MISS = 2'd0;
  localparam logic [1:0] SR_HIT  = 2'd1;
  localparam logic [1:0] SR_HITM = 2'd2;

  localparam int               LINES    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_BUS_ARB,
    S_BUS_WAIT,
    S_CLEAR,
    S_RESPOND
  } fsm_t;

  fsm_t             state_q, state_d;
  logic [3:0]       mem [LINES];
  logic [7:0]       cmd_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic [1:0]       op_q;
  logic [3:0]       next_q;
  logic             hit_q;
  logic [1:0]       snoop_q;

  logic [3:0]       cur;
  logic             lk_bus;
  logic [1:0]       lk_op;
  logic [3:0]       lk_next;
  logic             lk_hit;
  logic [1:0]       lk_snoop;

  // Protocol table; corrupted (non-one-hot) entries decode as Invalid.
  always_comb begin
    case (mem[idx_q])
      ST_M, ST_E, ST_S: cur = mem[idx_q];
      default:          cur = ST_I;
    endcase
    lk_hit   = (cur != ST_I);
    lk_bus   = 1'b0;
    lk_op    = OP_READ;
    lk_next  = cur;
    lk_snoop = SR_MISS;
    case (cmd_q)
      8'd0, 8'd2: begin
        if (!lk_hit) begin
          lk_bus  = 1'b1;
          lk_op   = OP_READ;
          lk_next = ST_E;
        end
      end
      8'd1: begin
        lk_next = ST_M;
        if (cur == ST_S) begin
          lk_bus = 1'b1;
          lk_op  = OP_INV;
        end else if (cur == ST_I) begin
          lk_bus = 1'b1;
          lk_op  = OP_RWIM;
        end
      end
      8'd3: begin
        if (lk_hit) begin
          lk_snoop = SR_HIT;
          if (cur == ST_S) lk_next = ST_I;
        end
      end
      8'd4: begin
        if (cur == ST_M) begin
          lk_bus   = 1'b1;
          lk_op    = OP_WB;
          lk_next  = ST_S;
          lk_snoop = SR_HITM;
        end else if (lk_hit) begin
          lk_next  = ST_S;
          lk_snoop = SR_HIT;
        end
      end
      8'd5: begin
        if (cur == ST_M)  lk_snoop = SR_HITM;
        else if (lk_hit)  lk_snoop = SR_HIT;
      end
      8'd6: begin
        if (cur == ST_M) begin
          lk_bus   = 1'b1;
          lk_op    = OP_WB;
          lk_next  = ST_I;
          lk_snoop = SR_HITM;
        end else if (lk_hit) begin
          lk_next  = ST_I;
          lk_snoop = SR_HIT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    REQ_READY = 1'b0;
    BUS_REQ   = 1'b0;
    BUS_OP    = 2'd0;
    RSP_VALID = 1'b0;
    BUSY      = 1'b1;
    case (state_q)
      S_IDLE: begin
        REQ_READY = 1'b1;
        BUSY      = 1'b0;
        if (REQ_VALID) state_d = (REQ_CMD == 8'd8) ? S_CLEAR : S_LOOKUP;
      end
      S_LOOKUP:   state_d = lk_bus ? S_BUS_ARB : S_RESPOND;
      S_BUS_ARB: begin
        BUS_REQ = 1'b1;
        BUS_OP  = op_q;
        if (BUS_GNT) state_d = S_BUS_WAIT;
      end
      S_BUS_WAIT: if (BUS_DONE) state_d = S_RESPOND;
      S_CLEAR:    if (clr_idx_q == LAST_IDX) state_d = S_RESPOND;
      S_RESPOND: begin
        RSP_VALID = 1'b1;
        state_d   = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cmd_q     <= 8'd0;
      idx_q     <= '0;
      clr_idx_q <= '0;
      op_q      <= OP_READ;
      next_q    <= ST_I;
      hit_q     <= 1'b0;
      snoop_q   <= SR_MISS;
      for (int i = 0; i < LINES; i++) mem[i] <= ST_I;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (REQ_VALID) begin
            cmd_q     <= REQ_CMD;
            idx_q     <= REQ_INDEX;
            clr_idx_q <= '0;
            if (REQ_CMD == 8'd8) begin
              next_q  <= ST_I;
              hit_q   <= 1'b0;
              snoop_q <= SR_MISS;
            end
          end
        end
        S_LOOKUP: begin
          op_q    <= lk_op;
          next_q  <= lk_next;
          hit_q   <= lk_hit;
          snoop_q <= lk_snoop;
        end
        S_BUS_WAIT: begin
          // A read miss lands in S if any other cache holds the line.
          if (BUS_DONE && op_q == OP_READ) next_q <= (BUS_HM != 2'd0) ? ST_S : ST_E;
        end
        S_CLEAR: begin
          mem[clr_idx_q] <= ST_I;
          if (clr_idx_q != LAST_IDX) clr_idx_q <= clr_idx_q + IDX_W'(1);
        end
        S_RESPOND: mem[idx_q] <= next_q;
        default: ;
      endcase
    end
  end

  assign RSP_STATE    = next_q;
  assign RSP_HIT      = hit_q;
  assign SNOOP_RESULT = snoop_q;

endmodule

// File: doc/mesi_line_controller.md
Name: mesi_line_controller

Overview:
- Sequencing controller for the MESI next-state logic. Owns a small per-line state array and accepts one trace command at a time through a valid/ready handshake.
- For each command it looks up the line's state and, when the protocol needs it, runs one front-side-bus transaction (READ, RWIM, INVALIDATE, WRITEBACK). It then writes the next state back and returns a response.
- Sits between the trace/command front end and the FSB interface.

Parameters:
- IDX_W, 4, line index width; array holds 2**IDX_W lines.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  command present.
- REQ_READY  out  1  controller can accept a command.
- REQ_CMD  in  8  trace command code.
- REQ_INDEX  in  IDX_W  target line.
- BUS_REQ  out  1  FSB transaction request.
- BUS_OP  out  2  0 READ, 1 RWIM, 2 INVALIDATE, 3 WRITEBACK.
- BUS_GNT  in  1  FSB grant.
- BUS_DONE  in  1  transaction complete, one-cycle pulse.
- BUS_HM  in  2  snoop result of our READ: 0 MISS, 1 HIT, 2 HITM, 3 treated as HITM.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_STATE  out  4  new line state.
- RSP_HIT  out  1  line was valid (M/E/S) before the command.
- SNOOP_RESULT  out  2  our answer to a snooped command: 0 MISS, 1 HIT, 2 HITM; 0 for local commands.
- BUSY  out  1  high whenever not IDLE.

Behaviour:
- State encoding is one-hot: M=4'b0001, E=4'b0010, S=4'b0100, I=4'b1000. Any non-one-hot stored value is read as I.
- Reset (RESET_N low at a clock edge):
  - All array entries go to I; FSM goes to IDLE.
  - REQ_READY=1; BUS_REQ=0; BUS_OP=0; RSP_VALID=0; RSP_STATE=I; RSP_HIT=0; SNOOP_RESULT=0; BUSY=0.
  - Reset mid-operation aborts it: BUS_REQ drops the next cycle and no response is issued.
- FSM states: IDLE, LOOKUP, BUS_ARB, BUS_WAIT, CLEAR, RESPOND.
  - IDLE: REQ_READY=1. On REQ_VALID, latch CMD and INDEX, then go to LOOKUP (CMD 8 goes to CLEAR).
  - LOOKUP: read the latched line state, compute the bus op (if any), next state and SNOOP_RESULT. Go to BUS_ARB if a bus op is needed, else RESPOND.
  - BUS_ARB: BUS_REQ=1 with BUS_OP held stable until BUS_GNT is sampled high, then go to BUS_WAIT (BUS_REQ=0).
  - BUS_WAIT: wait for BUS_DONE. For READ, BUS_HM is sampled in the BUS_DONE cycle. Then go to RESPOND.
  - RESPOND: write the next state, RSP_VALID=1 for exactly one cycle, return to IDLE.
- Latency:
  - No-bus command accepted at edge T: RSP_VALID high in cycle T+2.
  - Bus command: response 1 cycle after the BUS_DONE cycle.
- Protocol rules (current state -> bus op, next state):
  - CMD 0/2 (read): M/E/S -> none, unchanged. I -> READ, then S if BUS_HM!=0, else E.
  - CMD 1 (write): M/E -> none, M. S -> INVALIDATE, M. I -> RWIM, M.
  - CMD 3 (snooped invalidate): S -> I with HIT. M/E unchanged with HIT. I -> MISS.
  - CMD 4 (snooped read): M -> WRITEBACK, S, HITM. E/S -> S, HIT. I -> I, MISS.
  - CMD 5 (snooped write): state unchanged. Result M=HITM, E/S=HIT, I=MISS.
  - CMD 6 (snooped RWIM): M -> WRITEBACK, I, HITM. E/S -> I, HIT. I -> MISS.
  - CMD 8 (clear): CLEAR writes I to one index per cycle, 0 up to 2**IDX_W-1, then RESPOND with RSP_STATE=I, RSP_HIT=0.
  - CMD 9 and all other codes: no-op. Respond with the current state; RSP_HIT set per state.
- BUS_DONE, BUS_GNT and BUS_HM are ignored outside BUS_ARB/BUS_WAIT.
- A new request is never accepted in the same cycle as RSP_VALID.
- Index wrap: the CLEAR counter stops at the last index and does not wrap.

Test Plan:
- Reset, then CMD0 idx 3 with BUS_HM=0 at BUS_DONE -> BUS_OP=READ; RSP_STATE=4'b0010, RSP_HIT=0.
- CMD1 idx 3 (state E) -> no BUS_REQ; RSP_VALID exactly 2 cycles after accept; RSP_STATE=4'b0001, RSP_HIT=1.
- CMD4 idx 3 (state M), BUS_GNT delayed 5 cycles -> BUS_REQ/BUS_OP=3 held 5 cycles; SNOOP_RESULT=2; RSP_STATE=4'b0100.
- CMD1 idx 5 (state I) -> BUS_OP=RWIM; RSP_STATE=M. Then CMD6 idx 5 -> WRITEBACK; RSP_STATE=I; SNOOP_RESULT=2.
- Fill lines 0..15 to S, then CMD8 -> BUSY for 16+ cycles; CMD9 on every index returns 4'b1000.
- RESET_N low while in BUS_ARB -> BUS_REQ=0 and REQ_READY=1 next cycle; no RSP_VALID; all lines read back I.
